// File: rtl/layer2.sv
// Second fully-connected MNIST stage: ReLU over hidden sums, MAC against W2 over Avalon-MM,
// writes 10 saturated class scores and reports the argmax class.
module layer2 #(
    parameter logic [31:0] L1_BASE  = 32'd400_000,
    parameter logic [31:0] W2_BASE  = 32'd200_000,
    parameter logic [31:0] OUT_BASE = 32'd500_000,
    parameter int          N_IN     = 200,
    parameter int          N_OUT    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [15:0] readdata,
    output logic        chipselect,
    output logic [1:0]  byteenable,
    output logic        read_n,
    output logic        write_n,
    output logic [31:0] address,
    output logic [15:0] writedata,
    input  logic        ready,
    output logic        done,
    output logic [3:0]  class_out,
    output logic [31:0] toHexLed
);

    typedef enum logic [3:0] {
        IDLE, RD_L1, WT_L1, RD_W2, WT_W2, MAC, WR_OUT, NEXT, DONE
    } state_t;

    state_t             state, state_d;
    logic [7:0]         i, i_d;
    logic [3:0]         j, j_d;
    logic signed [15:0] act, act_d;
    logic signed [15:0] w, w_d;
    logic signed [31:0] acc, acc_d;
    logic signed [15:0] best_val, best_val_d;
    logic [3:0]         best_idx, best_idx_d;
    logic [3:0]         class_d;
    logic signed [15:0] sat_acc;
    logic signed [31:0] product;
    logic [31:0]        w2_index;
    logic               accepted;
    logic               better;

    assign accepted = !waitrequest;
    assign product  = 32'(act) * 32'(w);
    assign w2_index = 32'(j) * 32'(N_IN) + 32'(i);
    assign better   = sat_acc > best_val;

    always_comb begin
        if (acc > 32'sd32767)
            sat_acc = 16'sh7FFF;
        else if (acc < -32'sd32768)
            sat_acc = 16'sh8000;
        else
            sat_acc = acc[15:0];
    end

    // Bus outputs depend only on registered state and counters.
    always_comb begin
        chipselect = 1'b1;
        byteenable = 2'b11;
        read_n     = !(state == RD_L1 || state == RD_W2);
        write_n    = (state != WR_OUT);
        done       = (state == DONE);
        writedata  = (state == WR_OUT) ? sat_acc : 16'h0000;
        case (state)
            RD_L1:   address = L1_BASE + {23'b0, i, 1'b0};
            RD_W2:   address = W2_BASE + {w2_index[30:0], 1'b0};
            WR_OUT:  address = OUT_BASE + {27'b0, j, 1'b0};
            default: address = 32'h0;
        endcase
        toHexLed = {24'h0, class_out, state};
    end

    always_comb begin
        state_d    = state;
        i_d        = i;
        j_d        = j;
        act_d      = act;
        w_d        = w;
        acc_d      = acc;
        best_val_d = best_val;
        best_idx_d = best_idx;
        class_d    = class_out;
        case (state)
            IDLE: begin
                if (ready) begin
                    state_d    = RD_L1;
                    i_d        = 8'd0;
                    j_d        = 4'd0;
                    acc_d      = 32'sd0;
                    best_val_d = 16'sh8000;
                    best_idx_d = 4'd0;
                end
            end
            RD_L1:  if (accepted) state_d = WT_L1;
            WT_L1: begin
                if (readdatavalid) begin
                    act_d   = readdata[15] ? 16'sd0 : readdata;
                    state_d = RD_W2;
                end
            end
            RD_W2:  if (accepted) state_d = WT_W2;
            WT_W2: begin
                if (readdatavalid) begin
                    w_d     = readdata;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc + product;
                if (i == 8'(N_IN - 1)) begin
                    state_d = WR_OUT;
                end else begin
                    i_d     = i + 8'd1;
                    state_d = RD_L1;
                end
            end
            WR_OUT: if (accepted) state_d = NEXT;
            NEXT: begin
                // Strict compare so ties keep the lowest class index.
                if (better) begin
                    best_val_d = sat_acc;
                    best_idx_d = j;
                end
                acc_d = 32'sd0;
                i_d   = 8'd0;
                if (j == 4'(N_OUT - 1)) begin
                    class_d = better ? j : best_idx;
                    state_d = DONE;
                end else begin
                    j_d     = j + 4'd1;
                    state_d = RD_L1;
                end
            end
            DONE:    if (!ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            i         <= 8'd0;
            j         <= 4'd0;
            act       <= 16'sd0;
            w         <= 16'sd0;
            acc       <= 32'sd0;
            best_val  <= 16'sh8000;
            best_idx  <= 4'd0;
            class_out <= 4'd0;
        end else begin
            state     <= state_d;
            i         <= i_d;
            j         <= j_d;
            act       <= act_d;
            w         <= w_d;
            acc       <= acc_d;
            best_val  <= best_val_d;
            best_idx  <= best_idx_d;
            class_out <= class_d;
        end
    end

endmodule
